// File: rtl/uart_recv_if.sv
// Byte-delivery handshake between the UART receiver and its consumer.
// The receiver drives the master side; the consumer (CPU, FIFO, parser) uses the slave side.
interface uart_recv_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ack;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  modport master (
    output data_out,
    output data_valid,
    output busy,
    output frame_err,
    output overrun,
    input  data_ack
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  busy,
    input  frame_err,
    input  overrun,
    output data_ack
  );
endinterface

// File: rtl/uart_recv.sv
// 8N1 UART receiver with 16x oversampling from a fractional-N baud accumulator.
// Received bytes are offered on a valid/ack handshake; the line is never stalled.
module uart_recv #(
  parameter int BAUD_INC = 1152,
  parameter int BAUD_MOD = 62500,
  parameter int ACC_W    = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_in,
  uart_recv_if.master  bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  state_t           state_q, state_d;
  logic             armed_q, armed_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic [ACC_W-1:0] acc_sum;
  logic             tick;
  logic             rx_s;
  logic             deliver;

  always_comb begin
    acc_sum      = acc_q + ACC_W'(BAUD_INC);
    tick         = (acc_sum >= ACC_W'(BAUD_MOD));
    acc_d        = tick ? (acc_sum - ACC_W'(BAUD_MOD)) : acc_sum;

    sync1_d      = rx_in;
    sync2_d      = sync1_q;
    rx_s         = sync2_q;

    state_d      = state_q;
    armed_d      = armed_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    deliver      = 1'b0;

    if (data_valid_q && bus.data_ack) begin
      data_valid_d = 1'b0;
    end

    // A start edge is only accepted after the line has been seen high,
    // so a held-low break cannot retrigger the receiver.
    case (state_q)
      IDLE: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end
        if (armed_q && !rx_s) begin
          state_d = START;
          cnt_d   = 4'd0;
          armed_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (cnt_q == 4'd7) begin
            cnt_d = 4'd0;
            if (!rx_s) begin
              state_d   = DATA;
              bit_idx_d = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_q == 4'd15) begin
            cnt_d              = 4'd0;
            shift_d[bit_idx_q] = rx_s;
            if (bit_idx_q == 3'd7) begin
              state_d = STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (cnt_q == 4'd15) begin
            cnt_d   = 4'd0;
            state_d = IDLE;
            if (rx_s) begin
              deliver = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An ack in the delivery cycle frees the slot, so the new byte wins.
    if (deliver) begin
      if (!data_valid_q || bus.data_ack) begin
        data_out_d   = shift_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      acc_q        <= '0;
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      cnt_q        <= 4'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      acc_q        <= acc_d;
      state_q      <= state_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv: table of whole frames plus hand-written corner sequences.
// A faster baud ratio (3/20, about 106.7 clk per bit) keeps the run short while staying fractional.
module tb_uart_recv;

  localparam int BIT_CLK = 107;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_in = 1'b1;

  uart_recv_if bus();

  uart_recv #(
    .BAUD_INC (3),
    .BAUD_MOD (20),
    .ACC_W    (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_in (rx_in),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total_checks  = 0;
  int passed_checks = 0;
  int ferr_cnt      = 0;
  int ovr_cnt       = 0;

  // Pulse counters: each clk the pulse is high adds one, so a count of 1 is a single-cycle pulse.
  always @(negedge clk) begin
    if (bus.frame_err) ferr_cnt++;
    if (bus.overrun)   ovr_cnt++;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [7:0] tx_byte;
    logic       stop_bit;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total_checks++;
    if (actual === expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_in = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Sends one 8N1 frame LSB first; the line is left at the stop-bit level.
  task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(b[i]);
      if (i == 3) check_output("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
    end
    drive_bit(stop_bit);
  endtask

  task automatic ack_byte(input string name);
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
    check_output(name, {31'd0, bus.data_valid}, 32'd0);
  endtask

  initial begin
    int base_f;
    int base_o;
    int w;
    logic [7:0] got [2];

    bus.data_ack = 1'b0;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 0};
    vecs[1] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 0};
    vecs[2] = '{8'h81, 1'b0, 8'h3C, 1'b0, 1};
    vecs[3] = '{8'h42, 1'b1, 8'h42, 1'b1, 0};
    vecs[4] = '{8'h00, 1'b1, 8'h00, 1'b1, 0};
    vecs[5] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 0};
    vecs[6] = '{8'h96, 1'b1, 8'h96, 1'b1, 0};

    repeat (3) @(negedge clk);
    check_output("reset_data_out",   {24'd0, bus.data_out},   32'h00);
    check_output("reset_data_valid", {31'd0, bus.data_valid}, 32'd0);
    check_output("reset_busy",       {31'd0, bus.busy},       32'd0);
    check_output("reset_frame_err",  {31'd0, bus.frame_err},  32'd0);
    check_output("reset_overrun",    {31'd0, bus.overrun},    32'd0);
    rst_n = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);

    // Delivery latency: valid must stay low until the stop-bit centre, then rise shortly after.
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(8'hA5 >> i);
    rx_in = 1'b1;
    repeat (BIT_CLK / 2 - 10) @(negedge clk);
    check_output("latency_valid_early", {31'd0, bus.data_valid}, 32'd0);
    w = 0;
    while (!bus.data_valid && w < 30) begin
      @(negedge clk);
      w++;
    end
    check_output("latency_valid_rise", {31'd0, bus.data_valid}, 32'd1);
    check_output("latency_data",       {24'd0, bus.data_out},   32'hA5);
    repeat (BIT_CLK) @(negedge clk);
    check_output("latency_busy_after", {31'd0, bus.busy}, 32'd0);
    ack_byte("latency_ack");
    drive_bit(1'b1);

    for (int i = 0; i < 7; i++) begin
      base_f = ferr_cnt;
      base_o = ovr_cnt;
      apply_stimulus(vecs[i].tx_byte, vecs[i].stop_bit);
      rx_in = 1'b1;
      check_output($sformatf("vec%0d_valid", i), {31'd0, bus.data_valid}, {31'd0, vecs[i].exp_valid});
      check_output($sformatf("vec%0d_data", i),  {24'd0, bus.data_out},   {24'd0, vecs[i].exp_data});
      check_output($sformatf("vec%0d_ferr", i),  ferr_cnt - base_f,       vecs[i].exp_ferr);
      check_output($sformatf("vec%0d_ovr", i),   ovr_cnt - base_o,        32'd0);
      check_output($sformatf("vec%0d_busy", i),  {31'd0, bus.busy},       32'd0);
      if (vecs[i].exp_valid) ack_byte($sformatf("vec%0d_ack", i));
      drive_bit(1'b1);
    end

    // Short glitch: the start bit fails its mid-bit check and nothing is reported.
    base_f = ferr_cnt;
    rx_in = 1'b0;
    repeat (15) @(negedge clk);
    check_output("glitch_busy_seen", {31'd0, bus.busy}, 32'd1);
    repeat (5) @(negedge clk);
    rx_in = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check_output("glitch_busy",  {31'd0, bus.busy},       32'd0);
    check_output("glitch_valid", {31'd0, bus.data_valid}, 32'd0);
    check_output("glitch_ferr",  ferr_cnt - base_f,       32'd0);
    apply_stimulus(8'h3C, 1'b1);
    check_output("glitch_next_valid", {31'd0, bus.data_valid}, 32'd1);
    check_output("glitch_next_data",  {24'd0, bus.data_out},   32'h3C);
    ack_byte("glitch_next_ack");
    drive_bit(1'b1);

    // Framing error followed by a break: exactly one error and no restart while low.
    base_f = ferr_cnt;
    apply_stimulus(8'h81, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    check_output("break_busy_1", {31'd0, bus.busy}, 32'd0);
    repeat (BIT_CLK) @(negedge clk);
    check_output("break_busy_2", {31'd0, bus.busy},       32'd0);
    check_output("break_ferr",   ferr_cnt - base_f,       32'd1);
    check_output("break_valid",  {31'd0, bus.data_valid}, 32'd0);
    drive_bit(1'b1);
    apply_stimulus(8'h42, 1'b1);
    check_output("break_next_valid", {31'd0, bus.data_valid}, 32'd1);
    check_output("break_next_data",  {24'd0, bus.data_out},   32'h42);
    check_output("break_next_ferr",  ferr_cnt - base_f,       32'd1);
    ack_byte("break_next_ack");
    drive_bit(1'b1);

    // Overrun: an unread byte is kept and the newer one dropped.
    base_f = ferr_cnt;
    base_o = ovr_cnt;
    apply_stimulus(8'h11, 1'b1);
    drive_bit(1'b1);
    apply_stimulus(8'h22, 1'b1);
    check_output("ovr_data",  {24'd0, bus.data_out},   32'h11);
    check_output("ovr_valid", {31'd0, bus.data_valid}, 32'd1);
    check_output("ovr_pulse", ovr_cnt - base_o,        32'd1);
    check_output("ovr_ferr",  ferr_cnt - base_f,       32'd0);
    ack_byte("ovr_ack");
    drive_bit(1'b1);

    // Back-to-back frames with a consumer acking a few clk after each valid.
    base_f = ferr_cnt;
    base_o = ovr_cnt;
    fork
      begin
        apply_stimulus(8'h00, 1'b1);
        apply_stimulus(8'hFF, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          w = 0;
          while (!bus.data_valid && w < 30 * BIT_CLK) begin
            @(negedge clk);
            w++;
          end
          check_output($sformatf("b2b_valid_seen%0d", k), {31'd0, bus.data_valid}, 32'd1);
          repeat (3) @(negedge clk);
          got[k] = bus.data_out;
          ack_byte($sformatf("b2b_ack%0d", k));
        end
      end
    join
    check_output("b2b_byte0", {24'd0, got[0]},   32'h00);
    check_output("b2b_byte1", {24'd0, got[1]},   32'hFF);
    check_output("b2b_ferr",  ferr_cnt - base_f, 32'd0);
    check_output("b2b_ovr",   ovr_cnt - base_o,  32'd0);
    drive_bit(1'b1);

    // Reset during data bit 4 of 0x5A; the sender gives up and idles the line.
    base_f = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(8'h5A >> i);
    rx_in = 1'b1;
    repeat (BIT_CLK / 2) @(negedge clk);
    check_output("rst_busy_before", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_data_out",   {24'd0, bus.data_out},   32'h00);
    check_output("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
    check_output("rst_busy",       {31'd0, bus.busy},       32'd0);
    check_output("rst_frame_err",  {31'd0, bus.frame_err},  32'd0);
    check_output("rst_overrun",    {31'd0, bus.overrun},    32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * BIT_CLK) @(negedge clk);
    check_output("rst_after_valid", {31'd0, bus.data_valid}, 32'd0);
    check_output("rst_after_busy",  {31'd0, bus.busy},       32'd0);
    check_output("rst_after_ferr",  ferr_cnt - base_f,       32'd0);
    apply_stimulus(8'h96, 1'b1);
    check_output("rst_next_valid", {31'd0, bus.data_valid}, 32'd1);
    check_output("rst_next_data",  {24'd0, bus.data_out},   32'h96);
    ack_byte("rst_next_ack");
    drive_bit(1'b1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
